// File: rtl/dma_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_prog_pkg
// Purpose  : Shared types and helpers for the DMA register-programming bus
//            master: operation encoding, register address constants, FSM
//            state encodings, byte-index type and the per-byte bus-cycle
//            decode (address, write data, direction).
// Revision : 1.0 - initial release
// ============================================================================
package dma_prog_pkg;

    typedef enum logic [2:0] {
        OP_WR_CMD       = 3'd0,
        OP_WR_MODE      = 3'd1,
        OP_WR_BASE_ADDR = 3'd2,
        OP_WR_BASE_WC   = 3'd3,
        OP_RD_CUR_ADDR  = 3'd4,
        OP_RD_CUR_WC    = 3'd5,
        OP_RD_STATUS    = 3'd6,
        OP_CLR_FF       = 3'd7
    } dma_op_e;

    localparam logic [3:0] c_addr_cmd    = 4'b1000;
    localparam logic [3:0] c_addr_mode   = 4'b1011;
    localparam logic [3:0] c_addr_status = 4'b1000;
    localparam logic [3:0] c_addr_clr_ff = 4'b1100;

    // Byte index within a request: 16-bit ops use 0 = byte-pointer clear,
    // 1 = low byte, 2 = high byte; 8-bit ops only ever use index 0.
    typedef logic [1:0] byte_idx_t;

    // Request sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BUS = 2'd1,
        ST_CYCLE    = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_e;

    // Single-byte bus-cycle engine states
    typedef enum logic [1:0] {
        CY_IDLE   = 2'd0,
        CY_SETUP  = 2'd1,
        CY_STROBE = 2'd2,
        CY_HOLD   = 2'd3
    } cyc_state_e;

    function automatic logic is_wide(input dma_op_e op);
        return op inside {OP_WR_BASE_ADDR, OP_WR_BASE_WC, OP_RD_CUR_ADDR, OP_RD_CUR_WC};
    endfunction

    function automatic logic [3:0] byte_addr(input dma_op_e op, input logic [1:0] ch,
                                             input byte_idx_t idx);
        logic [3:0] a;
        a = c_addr_cmd;
        case (op)
            OP_WR_CMD:                      a = c_addr_cmd;
            OP_WR_MODE:                     a = c_addr_mode;
            OP_RD_STATUS:                   a = c_addr_status;
            OP_CLR_FF:                      a = c_addr_clr_ff;
            OP_WR_BASE_ADDR, OP_RD_CUR_ADDR: a = (idx == 2'd0) ? c_addr_clr_ff : {1'b0, ch, 1'b0};
            default:                        a = (idx == 2'd0) ? c_addr_clr_ff : {1'b0, ch, 1'b1};
        endcase
        return a;
    endfunction

    function automatic logic [7:0] byte_data(input dma_op_e op, input logic [15:0] data,
                                             input byte_idx_t idx);
        logic [7:0] d;
        d = 8'h00;
        if (is_wide(op)) begin
            if (idx == 2'd1)      d = data[7:0];
            else if (idx == 2'd2) d = data[15:8];
        end else if (op != OP_CLR_FF) begin
            d = data[7:0];
        end
        return d;
    endfunction

    function automatic logic byte_is_read(input dma_op_e op, input byte_idx_t idx);
        return (op == OP_RD_STATUS) ||
               ((op inside {OP_RD_CUR_ADDR, OP_RD_CUR_WC}) && (idx != 2'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_cycle
// Purpose  : Single-byte bus-cycle engine. On start it drives CS_N low with
//            address (and write data) for SETUP_CYCLES, pulses IOR_N/IOW_N
//            for STROBE_CYCLES, holds for HOLD_CYCLES, then releases CS_N.
// Ports    : clk, rst          - clock, async active-high reset
//            start_i           - launch a cycle (only honoured when idle)
//            isRead_i, addr_i, data_i - cycle direction, address, write byte
//            dbIn_i / rdByte_o - read data in / byte captured at strobe end
//            done_o            - high in the last HOLD cycle
//            csN_o, iorN_o, iowN_o, a_o, dbOut_o, dbOe_o - registered bus
// Revision : 1.0 - initial release
// ============================================================================
module dma_bus_cycle
    import dma_prog_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       isRead_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] data_i,
    input  logic [7:0] dbIn_i,
    output logic       done_o,
    output logic [7:0] rdByte_o,
    output logic       csN_o,
    output logic       iorN_o,
    output logic       iowN_o,
    output logic [3:0] a_o,
    output logic [7:0] dbOut_o,
    output logic       dbOe_o
);

    localparam logic [3:0] c_setup  = 4'(SETUP_CYCLES);
    localparam logic [3:0] c_strobe = 4'(STROBE_CYCLES);
    localparam logic [3:0] c_hold   = 4'(HOLD_CYCLES);

    cyc_state_e state_q;
    logic [3:0] cnt_q;
    logic       isRead_q;

    // Combinational so the sequencer can redirect on the very edge the cycle
    // ends, which keeps CS_N high for exactly one cycle between bytes.
    assign done_o = (state_q == CY_HOLD) && (cnt_q == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CY_IDLE;
            cnt_q    <= 4'd0;
            isRead_q <= 1'b0;
            rdByte_o <= 8'h00;
            csN_o    <= 1'b1;
            iorN_o   <= 1'b1;
            iowN_o   <= 1'b1;
            a_o      <= 4'd0;
            dbOut_o  <= 8'h00;
            dbOe_o   <= 1'b0;
        end else begin
            case (state_q)
                CY_IDLE: begin
                    if (start_i) begin
                        state_q  <= CY_SETUP;
                        cnt_q    <= c_setup;
                        isRead_q <= isRead_i;
                        csN_o    <= 1'b0;
                        a_o      <= addr_i;
                        dbOut_o  <= isRead_i ? 8'h00 : data_i;
                        dbOe_o   <= ~isRead_i;
                    end
                end
                CY_SETUP: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= CY_STROBE;
                        cnt_q   <= c_strobe;
                        iorN_o  <= ~isRead_q;
                        iowN_o  <= isRead_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CY_STROBE: begin
                    if (cnt_q == 4'd1) begin
                        if (isRead_q) rdByte_o <= dbIn_i;
                        state_q <= CY_HOLD;
                        cnt_q   <= c_hold;
                        iorN_o  <= 1'b1;
                        iowN_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CY_HOLD: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= CY_IDLE;
                        csN_o   <= 1'b1;
                        dbOe_o  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= CY_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_master
// Purpose  : CPU-side initiator for an 8237-style DMA controller. Accepts one
//            register-programming request at a time and emits the matching
//            CS_N/IOR_N/IOW_N/A/DB bus cycles. 16-bit registers are preceded
//            by a byte-pointer clear and then accessed low byte, high byte.
//            Bus cycles only start while HLDA is low.
// Ports    : CLK, RESET                      - clock, async active-high reset
//            reqValid/reqReady/reqOp/reqChannel/reqData - request handshake
//            rspValid/rspData                - one-cycle completion + read data
//            HLDA                            - bus hold acknowledge (gates start)
//            CS_N, IOR_N, IOW_N, A, dbOut, dbOe, dbIn - DMA register bus
// Config   : DMA_BUS_MASTER_SVA_EN - compiles in concurrent protocol assertions
// Revision : 1.0 - initial release
// ============================================================================
module dma_bus_master
    import dma_prog_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [2:0]  reqOp,
    input  logic [1:0]  reqChannel,
    input  logic [15:0] reqData,
    output logic        rspValid,
    output logic [15:0] rspData,
    input  logic        HLDA,
    output logic        CS_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic [3:0]  A,
    output logic [7:0]  dbOut,
    output logic        dbOe,
    input  logic [7:0]  dbIn
);

    seq_state_e  state_q;
    dma_op_e     op_q;
    logic [1:0]  ch_q;
    logic [15:0] data_q;
    byte_idx_t   idx_q;
    logic [7:0]  lowByte_q;
    logic        reqReady_q;
    logic        rspValid_q;
    logic [15:0] rspData_q;

    logic        w_start;
    logic        w_done;
    logic        w_isRead;
    logic        w_last;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [7:0]  w_rdByte;

    // HLDA is only looked at here; once a byte is launched it runs to the end.
    assign w_start  = (state_q == ST_WAIT_BUS) && !HLDA;
    assign w_addr   = byte_addr(op_q, ch_q, idx_q);
    assign w_data   = byte_data(op_q, data_q, idx_q);
    assign w_isRead = byte_is_read(op_q, idx_q);
    assign w_last   = !is_wide(op_q) || (idx_q == 2'd2);

    assign reqReady = reqReady_q;
    assign rspValid = rspValid_q;
    assign rspData  = rspData_q;

    dma_bus_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_cycle (
        .clk      (CLK),
        .rst      (RESET),
        .start_i  (w_start),
        .isRead_i (w_isRead),
        .addr_i   (w_addr),
        .data_i   (w_data),
        .dbIn_i   (dbIn),
        .done_o   (w_done),
        .rdByte_o (w_rdByte),
        .csN_o    (CS_N),
        .iorN_o   (IOR_N),
        .iowN_o   (IOW_N),
        .a_o      (A),
        .dbOut_o  (dbOut),
        .dbOe_o   (dbOe)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WR_CMD;
            ch_q       <= 2'd0;
            data_q     <= 16'h0000;
            idx_q      <= 2'd0;
            lowByte_q  <= 8'h00;
            reqReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspData_q  <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // reqReady comes up one cycle after reset release and
                    // drops on the accepting edge.
                    if (reqValid && reqReady_q) begin
                        op_q       <= dma_op_e'(reqOp);
                        ch_q       <= reqChannel;
                        data_q     <= reqData;
                        idx_q      <= 2'd0;
                        reqReady_q <= 1'b0;
                        state_q    <= ST_WAIT_BUS;
                    end else begin
                        reqReady_q <= 1'b1;
                    end
                end
                ST_WAIT_BUS: begin
                    if (!HLDA) state_q <= ST_CYCLE;
                end
                ST_CYCLE: begin
                    if (w_done) begin
                        if (idx_q == 2'd1) lowByte_q <= w_rdByte;
                        if (w_last) begin
                            rspValid_q <= 1'b1;
                            if (!w_isRead)         rspData_q <= 16'h0000;
                            else if (is_wide(op_q)) rspData_q <= {w_rdByte, lowByte_q};
                            else                   rspData_q <= {8'h00, w_rdByte};
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= ST_WAIT_BUS;
                        end
                    end
                end
                ST_DONE: begin
                    rspValid_q <= 1'b0;
                    reqReady_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DMA_BUS_MASTER_SVA_EN
    logic w_strobe;
    assign w_strobe = !IOR_N || !IOW_N;

    a_strobe_excl: assert property (@(posedge CLK) disable iff (RESET)
        !(!IOR_N && !IOW_N));
    a_strobe_cs: assert property (@(posedge CLK) disable iff (RESET)
        w_strobe |-> !CS_N);
    a_bus_stable: assert property (@(posedge CLK) disable iff (RESET)
        (!CS_N && $past(!CS_N)) |-> ($stable(A) && $stable(dbOut)));
    a_strobe_width: assert property (@(posedge CLK) disable iff (RESET)
        $rose(w_strobe) |-> w_strobe [*STROBE_CYCLES] ##1 !w_strobe);
    a_rsp_pulse: assert property (@(posedge CLK) disable iff (RESET)
        rspValid |=> !rspValid);
    a_no_accept_busy: assert property (@(posedge CLK) disable iff (RESET)
        (state_q != ST_IDLE) |-> !reqReady);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_bus_master
// Purpose  : Self-checking bench for dma_bus_master. Directed scenarios plus
//            randomized requests, each compared against a transaction-level
//            reference (expected bus-cycle list, latency and response).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_bus_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [2:0]  reqOp = 3'd0;
    logic [1:0]  reqChannel = 2'd0;
    logic [15:0] reqData = 16'h0;
    logic        rspValid;
    logic [15:0] rspData;
    logic        HLDA = 1'b0;
    logic        CS_N, IOR_N, IOW_N, dbOe;
    logic [3:0]  A;
    logic [7:0]  dbOut;
    logic [7:0]  dbIn = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dma_bus_master dut (
        .CLK(CLK), .RESET(RESET),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqChannel(reqChannel), .reqData(reqData),
        .rspValid(rspValid), .rspData(rspData), .HLDA(HLDA),
        .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
        .dbOut(dbOut), .dbOe(dbOe), .dbIn(dbIn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request end to end. Latency is counted in edges from the accepting
    // edge to the edge that samples rspValid high.
    task automatic transact(input int op, input int ch, input logic [15:0] data,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input int hlda, input bit keep, input bit do_rst);
        logic [3:0]  ea[3];
        bit          ew[3];
        logic [7:0]  ed[3];
        logic [3:0]  ga[3];
        logic        ge[3];
        logic [7:0]  gd[3];
        int          giw[3], gir[3];
        bit          gbad[3];
        int          n, nc, k, reads, lat;
        bit          hit;
        logic        pcs;
        logic [15:0] ersp;
        logic [3:0]  reg16;
        logic [1:0]  chl;

        chl = 2'(ch);
        n = 1; ersp = 16'h0; nc = 0; k = 0; reads = 0; lat = -1; hit = 0;
        for (int i = 0; i < 3; i++) begin
            ea[i] = 4'h0; ew[i] = 0; ed[i] = 8'h0; ga[i] = 4'h0; ge[i] = 1'b0;
            gd[i] = 8'h0; giw[i] = 0; gir[i] = 0; gbad[i] = 0;
        end
        // Reference: list of bus cycles the request must produce.
        case (op)
            0: begin ea[0] = 4'b1000; ew[0] = 1; ed[0] = data[7:0]; end
            1: begin ea[0] = 4'b1011; ew[0] = 1; ed[0] = data[7:0]; end
            6: begin ea[0] = 4'b1000; ew[0] = 0; ersp = {8'h00, b0}; end
            7: begin ea[0] = 4'b1100; ew[0] = 1; ed[0] = 8'h00; end
            default: begin
                n = 3;
                reg16 = {1'b0, chl, (op == 3 || op == 5) ? 1'b1 : 1'b0};
                ea[0] = 4'b1100; ew[0] = 1; ed[0] = 8'h00;
                ea[1] = reg16; ea[2] = reg16;
                ew[1] = (op < 4); ew[2] = (op < 4);
                ed[1] = data[7:0]; ed[2] = data[15:8];
                if (op >= 4) ersp = {b1, b0};
            end
        endcase

        reqValid = 1'b1; reqOp = 3'(op); reqChannel = chl; reqData = data;
        HLDA = (hlda > 0);
        for (int w = 0; w < 50 && reqReady !== 1'b1; w++) begin
            @(posedge CLK); #1;
        end
        chk("ready_wait", reqReady, 1);
        @(posedge CLK); #1;
        if (!keep) begin
            reqValid = 1'b0; reqOp = 3'($urandom); reqChannel = 2'($urandom);
            reqData = 16'($urandom);
        end
        chk("ready_drop_on_accept", reqReady, 0);
        pcs = CS_N;

        for (int c = 0; c < 200; c++) begin
            @(posedge CLK); #1;
            k++;
            if (k == hlda) HLDA = 1'b0;
            if (k <= hlda) chk("hlda_stall_cs", CS_N, 1);
            chk("strobe_excl", !IOR_N && !IOW_N, 0);
            chk("strobe_needs_cs", (!IOR_N || !IOW_N) && CS_N, 0);
            if (!CS_N && pcs) begin
                if (nc < 3) begin ga[nc] = A; ge[nc] = dbOe; gd[nc] = dbOut; end
                if (!dbOe) begin dbIn = (reads == 0) ? b0 : b1; reads++; end
                nc++;
            end else if (!CS_N && nc >= 1 && nc <= 3) begin
                if (A !== ga[nc-1] || dbOut !== gd[nc-1] || dbOe !== ge[nc-1])
                    gbad[nc-1] = 1;
            end
            if (!CS_N && nc >= 1 && nc <= 3) begin
                if (!IOW_N) giw[nc-1]++;
                if (!IOR_N) gir[nc-1]++;
            end
            pcs = CS_N;
            if (do_rst && !IOW_N) begin
                RESET = 1'b1; #1;
                chk("rst_cs_n", CS_N, 1);
                chk("rst_iow_n", IOW_N, 1);
                chk("rst_dboe", dbOe, 0);
                chk("rst_ready", reqReady, 0);
                hit = 1;
                break;
            end
            if (rspValid === 1'b1) begin
                lat = k + 1;
                chk("ready_low_in_rsp", reqReady, 0);
                break;
            end
        end

        if (do_rst) begin
            chk("rst_reached_strobe", hit, 1);
            @(posedge CLK); #1;
            chk("rst_hold_ready", reqReady, 0);
            chk("rst_hold_a", A, 0);
            chk("rst_hold_dbout", dbOut, 0);
            RESET = 1'b0; reqValid = 1'b0;
            @(posedge CLK); #1;
            chk("rst_ready_after_release", reqReady, 1);
            for (int c = 0; c < 20; c++) begin
                chk("rst_no_rsp", rspValid, 0);
                @(posedge CLK); #1;
            end
            return;
        end

        chk("latency", 32'(lat), 32'(5 * n + 1 + hlda));
        chk("cycle_count", 32'(nc), 32'(n));
        for (int i = 0; i < n && i < nc; i++) begin
            chk($sformatf("addr[%0d]", i), ga[i], ea[i]);
            chk($sformatf("dboe[%0d]", i), ge[i], ew[i]);
            if (ew[i]) chk($sformatf("dbout[%0d]", i), gd[i], ed[i]);
            chk($sformatf("iow_width[%0d]", i), 32'(giw[i]), ew[i] ? 2 : 0);
            chk($sformatf("ior_width[%0d]", i), 32'(gir[i]), ew[i] ? 0 : 2);
            chk($sformatf("bus_stable[%0d]", i), gbad[i], 0);
        end
        chk("rsp_data", rspData, ersp);
        @(posedge CLK); #1;
        chk("rsp_one_cycle", rspValid, 0);
        chk("ready_after_rsp", reqReady, 1);
    endtask

    initial begin
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_cs_n", CS_N, 1);
        chk("reset_ior_n", IOR_N, 1);
        chk("reset_iow_n", IOW_N, 1);
        chk("reset_a", A, 0);
        chk("reset_dbout", dbOut, 0);
        chk("reset_dboe", dbOe, 0);
        chk("reset_ready", reqReady, 0);
        chk("reset_rspvalid", rspValid, 0);
        chk("reset_rspdata", rspData, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("ready_after_release", reqReady, 1);

        // Directed scenarios
        transact(0, 0, 16'h0024, 8'h00, 8'h00, 0, 0, 0);    // WR_CMD
        transact(2, 2, 16'h1234, 8'h00, 8'h00, 0, 0, 0);    // WR_BASE_ADDR ch2
        transact(5, 1, 16'h0000, 8'hCD, 8'hAB, 0, 0, 0);    // RD_CUR_WC ch1
        transact(0, 0, 16'h0055, 8'h00, 8'h00, 10, 0, 0);   // HLDA stall
        transact(3, 3, 16'hBEEF, 8'h00, 8'h00, 0, 0, 1);    // reset mid-strobe
        transact(6, 0, 16'h0000, 8'h5A, 8'h00, 0, 1, 0);    // back-to-back status
        transact(6, 0, 16'h0000, 8'hA5, 8'h00, 0, 0, 0);
        transact(7, 0, 16'hFFFF, 8'h00, 8'h00, 0, 0, 0);    // CLR_FF
        transact(1, 0, 16'hC3C3, 8'h00, 8'h00, 0, 0, 0);    // WR_MODE
        transact(4, 3, 16'h0000, 8'h01, 8'hFE, 3, 0, 0);    // RD_CUR_ADDR ch3

        for (int r = 0; r < 24; r++) begin
            int h;
            h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            transact(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     16'($urandom), 8'($urandom), 8'($urandom), h, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
